tlul_timer: RTL

// - TL-UL responder (device end of the bus driven by the cpu's tlul_socket_m1 mux).
// - RISC-V style 64-bit mtime/mtimecmp timer with a control register.
// - Drives the core's timer_irq_i input.
// - Accepts one request at a time; the response is held in a single-entry buffer until d_ready.

---
 rtl/tlul_timer_if.sv | 32 +++
 rtl/tlul_timer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tlul_timer_if.sv
// TL-UL A/D channel bundle between a host (master) and the timer device (slave).
interface tlul_timer_if;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_ready;

  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic        d_error;
  logic        d_ready;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );
endinterface

// File: rtl/tlul_timer.sv
// TL-UL responder with a 64-bit mtime/mtimecmp timer and registered level interrupt.
// Define TLUL_TIMER_PRESCALER_EN to add the PRESCALE register at offset 0x14.
module tlul_timer #(
  parameter int          AddrBits    = 5,
  parameter logic [63:0] MtimecmpRst = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  tlul_timer_if.slave tl,
  output logic        timer_irq_o
);
  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpGet        = 3'd4;
  localparam logic [2:0] OpAck        = 3'd0;
  localparam logic [2:0] OpAckData    = 3'd1;

  localparam logic [AddrBits-1:0] OffMtimeLo    = AddrBits'(5'h00);
  localparam logic [AddrBits-1:0] OffMtimeHi    = AddrBits'(5'h04);
  localparam logic [AddrBits-1:0] OffMtimecmpLo = AddrBits'(5'h08);
  localparam logic [AddrBits-1:0] OffMtimecmpHi = AddrBits'(5'h0C);
  localparam logic [AddrBits-1:0] OffCtrl       = AddrBits'(5'h10);
  localparam logic [AddrBits-1:0] OffPrescale   = AddrBits'(5'h14);

  logic        rsp_valid_reg;
  logic [2:0]  rsp_opcode_reg;
  logic [1:0]  rsp_size_reg;
  logic [7:0]  rsp_source_reg;
  logic [31:0] rsp_data_reg;
  logic        rsp_error_reg;

  logic [31:0] mtime_lo_reg, mtime_hi_reg;
  logic [31:0] mtimecmp_lo_reg, mtimecmp_hi_reg;
  logic        en_reg;
  logic        irq_reg;

  logic [AddrBits-1:0] offset;
  logic        req, is_get, is_put, mapped, err, wr;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_prescale;
  logic [31:0] rd_value, bit_mask;
  logic [31:0] mtime_lo_next, mtime_hi_next;
  logic        tick;
  logic        unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                        input logic [31:0] bmask);
    return (old_val & ~bmask) | (new_val & bmask);
  endfunction

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign bit_mask[gi*8 +: 8] = {8{tl.a_mask[gi]}};
    end
  endgenerate

  assign offset      = tl.a_address[AddrBits-1:0];
  assign req         = tl.a_valid & ~rsp_valid_reg;
  assign is_get      = (tl.a_opcode == OpGet);
  assign is_put      = (tl.a_opcode == OpPutFull) | (tl.a_opcode == OpPutPartial);
  assign unused_bits = ^{tl.a_param, tl.a_address[31:AddrBits]};

`ifdef TLUL_TIMER_PRESCALER_EN
  logic [15:0] prescale_reg;
  logic [15:0] pre_cnt_reg;
  logic [15:0] prescale_wdata;

  assign prescale_wdata = (prescale_reg & ~bit_mask[15:0]) | (tl.a_data[15:0] & bit_mask[15:0]);
  assign tick           = en_reg & (pre_cnt_reg == 16'd0);

  // Counter sits at zero while disabled so enabling ticks on the very next edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prescale_reg <= 16'd0;
      pre_cnt_reg  <= 16'd0;
    end else begin
      if (wr_prescale) prescale_reg <= prescale_wdata;
      if (!en_reg)          pre_cnt_reg <= 16'd0;
      else if (wr_prescale) pre_cnt_reg <= prescale_wdata;
      else if (tick)        pre_cnt_reg <= prescale_reg;
      else                  pre_cnt_reg <= pre_cnt_reg - 16'd1;
    end
  end
`else
  assign tick = en_reg;
`endif

  always_comb begin
    mapped   = 1'b1;
    rd_value = '0;
    case (offset)
      OffMtimeLo:    rd_value = mtime_lo_reg;
      OffMtimeHi:    rd_value = mtime_hi_reg;
      OffMtimecmpLo: rd_value = mtimecmp_lo_reg;
      OffMtimecmpHi: rd_value = mtimecmp_hi_reg;
      OffCtrl:       rd_value = {31'd0, en_reg};
`ifdef TLUL_TIMER_PRESCALER_EN
      OffPrescale:   rd_value = {16'd0, prescale_reg};
`endif
      default:       mapped = 1'b0;
    endcase
  end

  assign err = ~mapped | (tl.a_address[1:0] != 2'b00) | (tl.a_size > 2'd2) | ~(is_get | is_put);
  assign wr  = req & is_put & ~err;

  assign wr_mtime_lo = wr & (offset == OffMtimeLo);
  assign wr_mtime_hi = wr & (offset == OffMtimeHi);
  assign wr_cmp_lo   = wr & (offset == OffMtimecmpLo);
  assign wr_cmp_hi   = wr & (offset == OffMtimecmpHi);
  assign wr_ctrl     = wr & (offset == OffCtrl);
  assign wr_prescale = wr & (offset == OffPrescale);

  // A bus write to a half beats that cycle's tick; a LO write also kills the carry into HI.
  always_comb begin
    mtime_lo_next = mtime_lo_reg;
    mtime_hi_next = mtime_hi_reg;
    if (wr_mtime_lo)
      mtime_lo_next = merge(mtime_lo_reg, tl.a_data, bit_mask);
    else if (tick)
      mtime_lo_next = mtime_lo_reg + 32'd1;
    if (wr_mtime_hi)
      mtime_hi_next = merge(mtime_hi_reg, tl.a_data, bit_mask);
    else if (tick && !wr_mtime_lo && (mtime_lo_reg == 32'hFFFF_FFFF))
      mtime_hi_next = mtime_hi_reg + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_lo_reg    <= 32'd0;
      mtime_hi_reg    <= 32'd0;
      mtimecmp_lo_reg <= MtimecmpRst[31:0];
      mtimecmp_hi_reg <= MtimecmpRst[63:32];
      en_reg          <= 1'b0;
      irq_reg         <= 1'b0;
    end else begin
      mtime_lo_reg <= mtime_lo_next;
      mtime_hi_reg <= mtime_hi_next;
      if (wr_cmp_lo) mtimecmp_lo_reg <= merge(mtimecmp_lo_reg, tl.a_data, bit_mask);
      if (wr_cmp_hi) mtimecmp_hi_reg <= merge(mtimecmp_hi_reg, tl.a_data, bit_mask);
      if (wr_ctrl && tl.a_mask[0]) en_reg <= tl.a_data[0];
      irq_reg <= en_reg & ({mtime_hi_reg, mtime_lo_reg} >= {mtimecmp_hi_reg, mtimecmp_lo_reg});
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_reg  <= 1'b0;
      rsp_opcode_reg <= OpAck;
      rsp_size_reg   <= 2'd0;
      rsp_source_reg <= 8'd0;
      rsp_data_reg   <= 32'd0;
      rsp_error_reg  <= 1'b0;
    end else if (req) begin
      rsp_valid_reg  <= 1'b1;
      rsp_opcode_reg <= is_get ? OpAckData : OpAck;
      rsp_size_reg   <= tl.a_size;
      rsp_source_reg <= tl.a_source;
      rsp_data_reg   <= (is_get && !err) ? rd_value : 32'd0;
      rsp_error_reg  <= err;
    end else if (rsp_valid_reg && tl.d_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign tl.a_ready   = ~rsp_valid_reg;
  assign tl.d_valid   = rsp_valid_reg;
  assign tl.d_opcode  = rsp_opcode_reg;
  assign tl.d_param   = 3'd0;
  assign tl.d_size    = rsp_size_reg;
  assign tl.d_source  = rsp_source_reg;
  assign tl.d_sink    = 1'b0;
  assign tl.d_data    = rsp_data_reg;
  assign tl.d_error   = rsp_error_reg;
  assign timer_irq_o  = irq_reg;
endmodule
